// File: rtl/seg_scan_display_if.sv
// Bus bundle for seg_scan_display: capture-side inputs and the scanned display outputs.
// With SEG_DP_EN defined the bundle also carries one decimal-point bit per digit.
interface seg_scan_display_if #(
   parameter int N_DIGITS = 8
);
   logic                  en;
   logic                  data_valid;
   logic [4*N_DIGITS-1:0] data_in;
   logic                  blank_lz;
`ifdef SEG_DP_EN
   logic [N_DIGITS-1:0]   dp_in;
`endif
   logic [7:0]            o_seg;
   logic [N_DIGITS-1:0]   o_sel;
   logic                  frame_done;

   modport master (
      output en, data_valid, data_in, blank_lz,
`ifdef SEG_DP_EN
      output dp_in,
`endif
      input  o_seg, o_sel, frame_done
   );

   modport slave (
      input  en, data_valid, data_in, blank_lz,
`ifdef SEG_DP_EN
      input  dp_in,
`endif
      output o_seg, o_sel, frame_done
   );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed N-digit hex 7-segment scanner with double-buffered, frame-aligned updates.
// Optional macro SEG_DP_EN adds per-digit decimal points (dp_in) carried with the data.
module seg_scan_display #(
   parameter int N_DIGITS   = 8,
   parameter int SCAN_DIV   = 100000,
   parameter bit ACTIVE_LOW = 1
) (
   input logic               clk_in,
   input logic               reset,
   seg_scan_display_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int DW = 4 * N_DIGITS;
   localparam logic [7:0]          SEG_OFF = {8{ACTIVE_LOW}};
   localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{ACTIVE_LOW}};

   // Active-low g..a pattern for one hex digit.
   function automatic logic [6:0] hex_to_seg_n(input logic [3:0] v);
      case (v)
         4'h0: hex_to_seg_n = 7'h40;
         4'h1: hex_to_seg_n = 7'h79;
         4'h2: hex_to_seg_n = 7'h24;
         4'h3: hex_to_seg_n = 7'h30;
         4'h4: hex_to_seg_n = 7'h19;
         4'h5: hex_to_seg_n = 7'h12;
         4'h6: hex_to_seg_n = 7'h02;
         4'h7: hex_to_seg_n = 7'h78;
         4'h8: hex_to_seg_n = 7'h00;
         4'h9: hex_to_seg_n = 7'h10;
         4'hA: hex_to_seg_n = 7'h08;
         4'hB: hex_to_seg_n = 7'h03;
         4'hC: hex_to_seg_n = 7'h46;
         4'hD: hex_to_seg_n = 7'h21;
         4'hE: hex_to_seg_n = 7'h06;
         default: hex_to_seg_n = 7'h0E;
      endcase
   endfunction

   logic [PW-1:0]       presc_q, presc_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DW-1:0]       shadow_q, shadow_d, disp_q, disp_d;
   logic                pending_q, pending_d;
   logic                frame_done_q, frame_done_d;
   logic [7:0]          seg_q, seg_d;
   logic [N_DIGITS-1:0] sel_q, sel_d;
`ifdef SEG_DP_EN
   logic [N_DIGITS-1:0] dp_shadow_q, dp_shadow_d, dp_disp_q, dp_disp_d;
`endif

   logic       tc, wrap, capture, blank;
   logic [3:0] nib;
   logic [7:0] seg_n;

   // NOTE: combinational logic uses blocking assignments and gives every output a
   // default first, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      tc      = (presc_q == PW'(SCAN_DIV - 1));
      wrap    = tc && (idx_q == IW'(N_DIGITS - 1));
      capture = bus.data_valid && bus.en;

      presc_d      = tc ? '0 : presc_q + PW'(1);
      idx_d        = idx_q;
      if (tc) idx_d = wrap ? '0 : idx_q + IW'(1);
      frame_done_d = wrap;

      shadow_d  = shadow_q;
      disp_d    = disp_q;
      pending_d = pending_q;
`ifdef SEG_DP_EN
      dp_shadow_d = dp_shadow_q;
      dp_disp_d   = dp_disp_q;
`endif
      // A write landing on the wrap edge bypasses the shadow so it shows next frame.
      if (wrap && capture) begin
         shadow_d  = bus.data_in;
         disp_d    = bus.data_in;
         pending_d = 1'b0;
`ifdef SEG_DP_EN
         dp_shadow_d = bus.dp_in;
         dp_disp_d   = bus.dp_in;
`endif
      end else begin
         if (wrap && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
`ifdef SEG_DP_EN
            dp_disp_d = dp_shadow_q;
`endif
         end
         if (capture) begin
            shadow_d  = bus.data_in;
            pending_d = 1'b1;
`ifdef SEG_DP_EN
            dp_shadow_d = bus.dp_in;
`endif
         end
      end

      nib   = 4'(disp_q >> (4 * int'(idx_q)));
      blank = bus.blank_lz && (idx_q != '0) && ((disp_q >> (4 * int'(idx_q))) == '0);
      seg_n = {1'b1, hex_to_seg_n(nib)};
`ifdef SEG_DP_EN
      seg_n[7] = ~dp_disp_q[idx_q];
`endif
      if (blank) seg_n = 8'hFF;

      seg_d = SEG_OFF;
      sel_d = SEL_OFF;
      if (bus.en) begin
         seg_d = ACTIVE_LOW ? seg_n : ~seg_n;
         sel_d = SEL_OFF ^ (N_DIGITS'(1) << idx_q);
      end
   end

   // NOTE: state registers use non-blocking assignments only; the reset here is
   // synchronous, so it is just the highest-priority branch of the clocked update.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         presc_q      <= '0;
         idx_q        <= '0;
         shadow_q     <= '0;
         disp_q       <= '0;
         pending_q    <= 1'b0;
         frame_done_q <= 1'b0;
         seg_q        <= SEG_OFF;
         sel_q        <= SEL_OFF;
`ifdef SEG_DP_EN
         dp_shadow_q  <= '0;
         dp_disp_q    <= '0;
`endif
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         shadow_q     <= shadow_d;
         disp_q       <= disp_d;
         pending_q    <= pending_d;
         frame_done_q <= frame_done_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
`ifdef SEG_DP_EN
         dp_shadow_q  <= dp_shadow_d;
         dp_disp_q    <= dp_disp_d;
`endif
      end
   end

   assign bus.o_seg      = seg_q;
   assign bus.o_sel      = sel_q;
   assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (8 digits, 4-cycle slots, active-low):
// a cycle-count based reference model checked every cycle, plus literal spot checks.
module tb_seg_scan_display;
   localparam int N  = 8;
   localparam int SD = 4;
   localparam int FRAME = N * SD;

   logic clk;
   logic reset;

   seg_scan_display_if #(.N_DIGITS(N)) bus ();

   seg_scan_display #(
      .N_DIGITS  (N),
      .SCAN_DIV  (SD),
      .ACTIVE_LOW(1)
   ) dut (
      .clk_in(clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total_checks = 0;
   int passed_checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act === exp) passed_checks++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: position in the scan follows from edges counted since reset.
   logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   int unsigned t;
   logic [31:0] m_disp, m_shadow;
   bit          m_pend;
   logic [7:0]  exp_seg, exp_sel;
   logic        exp_fd;
   bit          model_valid = 0;
   int          m_idx;
   bit          m_wrap, m_cap, m_blank;
   logic [3:0]  m_nib;

   always @(posedge clk) begin
      if (reset) begin
         t = 0;
         m_disp = '0;
         m_shadow = '0;
         m_pend = 0;
         exp_seg = 8'hFF;
         exp_sel = 8'hFF;
         exp_fd = 1'b0;
         model_valid = 1;
      end else begin
         m_idx   = (t / SD) % N;
         m_wrap  = (t % FRAME) == FRAME - 1;
         m_cap   = bus.data_valid && bus.en;
         m_nib   = m_disp[4*m_idx +: 4];
         m_blank = bus.blank_lz && (m_idx != 0) && ((m_disp >> (4*m_idx)) == 0);
         exp_sel = bus.en ? ~(8'h01 << m_idx) : 8'hFF;
         exp_seg = (!bus.en || m_blank) ? 8'hFF : seg_tab[m_nib];
         exp_fd  = m_wrap;
         if (m_cap && m_wrap) begin
            m_disp = bus.data_in;
            m_shadow = bus.data_in;
            m_pend = 0;
         end else begin
            if (m_wrap && m_pend) begin
               m_disp = m_shadow;
               m_pend = 0;
            end
            if (m_cap) begin
               m_shadow = bus.data_in;
               m_pend = 1;
            end
         end
         t++;
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("model_seg", bus.o_seg, exp_seg);
         check("model_sel", bus.o_sel, exp_sel);
         check("model_fd", bus.frame_done, exp_fd);
      end
   end

   task automatic wait_sel(input logic [7:0] v, input string name);
      int n = 0;
      while (bus.o_sel !== v && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reached"}, (n < 200), 1);
   endtask

   task automatic wait_fd(input string name);
      int n = 0;
      while (bus.frame_done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reached"}, (n < 200), 1);
   endtask

   task automatic wait_phase(input int ph, input string name);
      int n = 0;
      while ((t % FRAME) != ph && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_reached"}, (n < 200), 1);
   endtask

   task automatic write(input logic [31:0] v);
      bus.data_valid = 1'b1;
      bus.data_in = v;
      @(negedge clk);
      bus.data_valid = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      bus.en = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in = '0;
      bus.blank_lz = 1'b0;
`ifdef SEG_DP_EN
      bus.dp_in = '0;
`endif
      repeat (3) @(negedge clk);
      check("rst_seg", bus.o_seg, 8'hFF);
      check("rst_sel", bus.o_sel, 8'hFF);
      check("rst_fd", bus.frame_done, 1'b0);
      reset = 1'b0;
      bus.en = 1'b1;

      // Scan order and frame period.
      wait_sel(8'hFE, "sel0");
      @(negedge clk);
      check("sel0_held", bus.o_sel, 8'hFE);
      wait_sel(8'hFD, "sel1");
      wait_fd("fd_first");
      @(negedge clk);
      n = 1;
      while (bus.frame_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("frame_period", n, FRAME);

      // Mid-frame write is held until the frame boundary.
      wait_sel(8'hF7, "mid_idx3");
      write(32'h0123_ABCD);
      check("hold_old", bus.o_seg, 8'hC0);
      wait_fd("load_abcd");
      wait_sel(8'hFE, "abcd_d0");
      check("abcd_d0", bus.o_seg, 8'hA1);
      wait_sel(8'hF7, "abcd_d3");
      check("abcd_d3", bus.o_seg, 8'h88);
      wait_sel(8'h7F, "abcd_d7");
      check("abcd_d7", bus.o_seg, 8'hC0);

      // Write on the wrap edge shows in the very next frame.
      wait_phase(FRAME - 1, "wrap_phase");
      write(32'h0000_0005);
      check("bypass_fd", bus.frame_done, 1'b1);
      @(negedge clk);
      check("bypass_sel", bus.o_sel, 8'hFE);
      check("bypass_seg", bus.o_seg, 8'h92);

      // Leading-zero blanking.
      bus.blank_lz = 1'b1;
      write(32'h0000_0050);
      wait_fd("load_50");
      wait_sel(8'hFE, "lz_d0");
      check("lz_d0", bus.o_seg, 8'hC0);
      wait_sel(8'hFD, "lz_d1");
      check("lz_d1", bus.o_seg, 8'h92);
      wait_sel(8'hFB, "lz_d2");
      check("lz_d2", bus.o_seg, 8'hFF);
      wait_sel(8'h7F, "lz_d7");
      check("lz_d7", bus.o_seg, 8'hFF);
      write(32'h0000_0000);
      wait_fd("load_zero");
      wait_sel(8'hFE, "zero_d0");
      check("zero_d0", bus.o_seg, 8'hC0);
      wait_sel(8'hFD, "zero_d1");
      check("zero_d1", bus.o_seg, 8'hFF);

      // Disabled: outputs inactive and writes ignored.
      bus.en = 1'b0;
      write(32'hFFFF_FFFF);
      check("dis_seg", bus.o_seg, 8'hFF);
      check("dis_sel", bus.o_sel, 8'hFF);
      repeat (2 * FRAME) @(negedge clk);
      bus.en = 1'b1;
      wait_fd("reen_fd");
      wait_sel(8'hFE, "reen_d0");
      check("reen_d0", bus.o_seg, 8'hC0);
      wait_sel(8'hFD, "reen_d1");
      check("reen_d1", bus.o_seg, 8'hFF);

      // Reset at digit 5 with a pending write discards it.
      bus.blank_lz = 1'b0;
      wait_phase(4, "pend_phase");
      write(32'h8888_8888);
      wait_phase(5 * SD, "rst_phase");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_seg", bus.o_seg, 8'hFF);
      check("midrst_sel", bus.o_sel, 8'hFF);
      check("midrst_fd", bus.frame_done, 1'b0);
      @(negedge clk);
      check("midrst_restart", bus.o_sel, 8'hFE);
      wait_fd("post_rst_fd");
      wait_sel(8'hEF, "post_rst_d4");
      check("post_rst_d4", bus.o_seg, 8'hC0);

      // Randomized traffic, including writes steered onto wrap edges.
      for (int i = 0; i < 4000; i++) begin
         bus.en = ($urandom_range(0, 9) != 0);
         bus.data_valid = ($urandom_range(0, 15) == 0) ||
                          (((t % FRAME) == FRAME - 1) && ($urandom_range(0, 3) == 0));
         bus.data_in = $urandom >> (4 * $urandom_range(0, 8));
         if ($urandom_range(0, 199) == 0) bus.blank_lz = ~bus.blank_lz;
         reset = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      reset = 1'b0;
      bus.data_valid = 1'b0;
      repeat (FRAME) @(negedge clk);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end
endmodule
